serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Parametrised successor of the fixed 40-bit serial receiver: detects a start bit on a single-wire serial input, shifts in a configurable number of data bits in a configurable order, checks a stop bit and holds the completed word behind a valid/ready handshake. It sits between the serial pin (already synchronised) and the command decoder. It also supports bit-rate pacing via an enable strobe, and reports framing and overrun errors.

## Interface
- `DATA_BITS`, 40: frame payload width, 1..64.
- `MSB_FIRST`, 1: 1 = first received bit lands in `data[DATA_BITS-1]`; 0 = first bit lands in `data[0]`.
- `STOP_CHECK`, 1: 1 = stop bit must equal idle level 0; 0 = stop slot sampled but ignored.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `si`  in  1  serial in; idle 0, start bit 1.
- `bit_en`  in  1  bit strobe; `si` is sampled only on cycles with `bit_en`=1. Tie to 1 for one bit per clock.
- `data`  out  DATA_BITS  received word; stable while `data_valid`=1.
- `data_valid`  out  1  word available.
- `data_ready`  in  1  consumer accepts the word when `data_valid`&&`data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit was 1 (`STOP_CHECK`=1 only).
- `overrun`  out  1  one-cycle pulse: a frame completed while the previous word was still unaccepted.
- `busy`  out  1  receiver is in DATA or STOP.

## Operation
- State machine (IDLE, DATA, STOP). Transitions are evaluated only on `bit_en` cycles; on other cycles all state holds.
- IDLE: if `si`=1, go to DATA with the bit counter at 0. The start bit is not stored.
- DATA: shift `si` into the shift register and increment the counter. After the DATA_BITS-th bit, go to STOP.
  - `MSB_FIRST`=1 shifts left, inserting at bit 0.
  - `MSB_FIRST`=0 shifts right, inserting at bit DATA_BITS-1.
- STOP: sample `si`, then return to IDLE. The outcome depends on the stop bit and output state:
  - If `STOP_CHECK`=1 and `si`=1: pulse `frame_err` and discard the frame.
  - Otherwise, if `data_valid`=0, or `data_valid`=1 with `data_ready`=1 in the same cycle: load `data` and set `data_valid`.
  - Otherwise: pulse `overrun` and discard the new frame. The held `data` is kept.
- The handshake clears `data_valid` on the cycle of acceptance, unless a new word loads in that same cycle.
- The counter width is $clog2(DATA_BITS+1) and it never wraps past DATA_BITS.
- A start bit is accepted on the `bit_en` cycle immediately after STOP; frames may be back-to-back.
- `rst` forces state to IDLE, counter to 0, shift register to 0 and all outputs to 0. This includes reset mid-frame; the partial frame is lost.

## Timing
- With `bit_en`=1 constantly, let the start bit be sampled at edge T.
  - Data bits are sampled at edges T+1..T+DATA_BITS.
  - The stop bit is sampled at edge T+DATA_BITS+1.
  - `data_valid`, `frame_err` or `overrun` is visible after edge T+DATA_BITS+1.
  - The frame period is DATA_BITS+2 samples.
- `data_valid` stays high until the handshake; `data` does not change while it is high.
- `frame_err` and `overrun` are exactly one `clk` cycle wide, even when `bit_en` is sparse.
- `bit_en` is low during a frame: there is no sampling and no timeout; the frame resumes at the next strobe.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `serial_rx_pkg`: state enum (IDLE/DATA/STOP) and a counter-width function.
- One sub-module, `serial_shift_reg`:
  - parameters DATA_BITS and MSB_FIRST;
  - ports: shift enable, serial bit, parallel output.
- The top level holds the FSM, counter and output/handshake register.

## Test plan
- Reset/idle: `rst` for 2 cycles, then `si`=0 for 10 cycles -> all outputs 0, `busy`=0.
- Default frame, `bit_en`=1, `data_ready`=1:
  - Stimulus: start 1, then 40 bits 1010_1001_1111_0000_1010…_1010_1001, then stop 0.
  - Response: `data`=40'hA9F0AAAAA9 and `data_valid` high one cycle after the stop-bit edge.
- LSB-first, DATA_BITS=8, MSB_FIRST=0: send bits 1,0,0,0,0,0,0,0 -> `data`=8'h01.
- Framing: stop bit 1 -> `frame_err` pulses one cycle, `data_valid` stays 0.
  - With STOP_CHECK=0, the same stimulus loads the word normally.
- Overrun, `data_ready`=0: two back-to-back frames 0x11… and 0x22… -> first word held, `overrun` pulses at the second stop bit.
  - Raising `data_ready` in the stop cycle instead loads the second word with no overrun.
- `bit_en` every 4th cycle plus `rst` asserted mid-frame after 10 bits:
  - Response: `busy` drops, no `data_valid`, and the next full frame is received correctly.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the parametrised serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } rx_state_e;

    // Bit counter must be able to hold the value DATA_BITS itself.
    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in / parallel-out shift register; direction chosen by MSB_FIRST.
module serial_shift_reg
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = 40,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 ser_in,
    output logic [DATA_BITS-1:0] par_out
);

    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [DATA_BITS-1:0] shifted;

    // Single-bit payloads have no slice to shift, so they get their own branch.
    if (DATA_BITS == 1) begin : g_one
        // Next value for a one-bit register is simply the incoming bit.
        always_comb shifted = ser_in;
    end else if (MSB_FIRST) begin : g_msb
        // Shift left: oldest bit ends up at the top.
        always_comb shifted = {shreg_q[DATA_BITS-2:0], ser_in};
    end else begin : g_lsb
        // Shift right: oldest bit ends up at the bottom.
        always_comb shifted = {ser_in, shreg_q[DATA_BITS-1:1]};
    end

    // Advance only on strobed data-bit cycles.
    always_comb begin
        shreg_d = shreg_q;
        if (shift_en) begin
            shreg_d = shifted;
        end
    end

    // Register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign par_out = shreg_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start-bit detect, payload shift, stop-bit check,
// valid/ready output holding register with framing and overrun pulses.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 40,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          STOP_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 si,
    input  logic                 bit_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned     CW       = cnt_width(DATA_BITS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic                 shift_en;
    logic [DATA_BITS-1:0] shreg;

    assign shift_en = bit_en && (state_q == ST_DATA);

    serial_shift_reg #(
        .DATA_BITS (DATA_BITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .ser_in   (si),
        .par_out  (shreg)
    );

    // Next-state, counter and output-register logic; the FSM only moves on
    // strobe cycles, while the handshake is evaluated every clock.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        data_valid_d = data_valid_q && !data_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (si) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (STOP_CHECK && si) begin
                        frame_err_d = 1'b1;
                    end else if (!data_valid_q || data_ready) begin
                        data_d       = shreg;
                        data_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: one default instance (40 bits,
// MSB first, stop checked) and one 8-bit LSB-first instance without stop check.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  si_v, be_v, rdy_v;
    logic [39:0] data0;
    logic [7:0]  data1;
    logic [1:0]  dv, fe, ov, bz;
    logic [63:0] dout [2];

    serial_frame_rx #(
        .DATA_BITS  (40),
        .MSB_FIRST  (1'b1),
        .STOP_CHECK (1'b1)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .si         (si_v[0]),
        .bit_en     (be_v[0]),
        .data       (data0),
        .data_valid (dv[0]),
        .data_ready (rdy_v[0]),
        .frame_err  (fe[0]),
        .overrun    (ov[0]),
        .busy       (bz[0])
    );

    serial_frame_rx #(
        .DATA_BITS  (8),
        .MSB_FIRST  (1'b0),
        .STOP_CHECK (1'b0)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .si         (si_v[1]),
        .bit_en     (be_v[1]),
        .data       (data1),
        .data_valid (dv[1]),
        .data_ready (rdy_v[1]),
        .frame_err  (fe[1]),
        .overrun    (ov[1]),
        .busy       (bz[1])
    );

    assign dout[0] = {24'b0, data0};
    assign dout[1] = {56'b0, data1};

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; logic [63:0] w; int unsigned cyc; } dexp_t;
    typedef struct { int idx; bit is_ov; int unsigned cyc; } eexp_t;

    dexp_t dq[$];
    eexp_t eq[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  idle_req = '0;
    bit          end_req  = 1'b0;
    bit   [1:0]  m_held   = '0;

    // ---------------- monitor ----------------
    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    logic [1:0]  pv = '0;
    logic [1:0]  pa = '0;
    logic [63:0] pdata [2];

    always @(negedge clk) begin
        dexp_t de;
        eexp_t ee;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                if (dv[i] && (!pv[i] || pa[i])) begin
                    if (dq.size() == 0) begin
                        chk(1'b0, "unexpected_word", dout[i], 64'd0);
                    end else begin
                        de = dq.pop_front();
                        chk(de.idx == i, "word_dut", 64'(i), 64'(de.idx));
                        chk(dout[i] == de.w, "word_data", dout[i], de.w);
                        chk(cyc == de.cyc, "word_latency", 64'(cyc), 64'(de.cyc));
                    end
                end else if (dv[i] && pv[i]) begin
                    chk(dout[i] == pdata[i], "word_stable", dout[i], pdata[i]);
                end
                if (fe[i]) begin
                    if (eq.size() == 0) begin
                        chk(1'b0, "unexpected_frame_err", 64'(i), 64'd0);
                    end else begin
                        ee = eq.pop_front();
                        chk(ee.idx == i && !ee.is_ov, "frame_err_kind", {63'd0, ee.is_ov}, 64'd0);
                        chk(cyc == ee.cyc, "frame_err_latency", 64'(cyc), 64'(ee.cyc));
                    end
                end
                if (ov[i]) begin
                    if (eq.size() == 0) begin
                        chk(1'b0, "unexpected_overrun", 64'(i), 64'd0);
                    end else begin
                        ee = eq.pop_front();
                        chk(ee.idx == i && ee.is_ov, "overrun_kind", {63'd0, ee.is_ov}, 64'd1);
                        chk(cyc == ee.cyc, "overrun_latency", 64'(cyc), 64'(ee.cyc));
                    end
                end
            end
            if (idle_req[i]) begin
                chk({dv[i], fe[i], ov[i], bz[i]} == 4'b0000, "idle_flags",
                    {60'd0, dv[i], fe[i], ov[i], bz[i]}, 64'd0);
                chk(dout[i] == 64'd0, "idle_data", dout[i], 64'd0);
            end
            pv[i]    <= dv[i];
            pa[i]    <= dv[i] & rdy_v[i];
            pdata[i] <= dout[i];
        end
        if (end_req) begin
            chk(dq.size() == 0, "words_outstanding", 64'(dq.size()), 64'd0);
            chk(eq.size() == 0, "errors_outstanding", 64'(eq.size()), 64'd0);
        end
    end

    // ---------------- reference model and drivers ----------------
    function automatic int dbits(input int i);
        return (i == 0) ? 40 : 8;
    endfunction

    // Word the receiver should hold after the frame: k-th transmitted bit goes
    // to data[DB-1-k] when MSB first, to data[k] when LSB first.
    function automatic logic [63:0] expect_word(input int i, input logic [63:0] seq);
        logic [63:0] w;
        int db;
        db = dbits(i);
        w  = '0;
        for (int k = 0; k < db; k++) begin
            if (i == 0) w[k] = seq[k];
            else        w[k] = seq[db-1-k];
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int i, input logic b, input int pace, output int unsigned ecyc);
        si_v[i] = b;
        for (int w = 1; w < pace; w++) begin
            be_v[i] = 1'b0;
            tick();
        end
        be_v[i] = 1'b1;
        ecyc = cyc + 1;
        tick();
    endtask

    // seq is transmitted from seq[DB-1] down to seq[0].
    task automatic send_frame(input int i, input logic [63:0] seq, input logic stopb, input int pace,
                              input logic rdy_data, input logic rdy_stop, input int gap);
        int unsigned ecyc;
        int db;
        db = dbits(i);
        if (rdy_data) m_held[i] = 1'b0;
        rdy_v[i] = rdy_data;
        step(i, 1'b1, pace, ecyc);
        for (int k = db - 1; k >= 0; k--) step(i, seq[k], pace, ecyc);
        rdy_v[i] = rdy_stop;
        step(i, stopb, pace, ecyc);
        if (stopb && i == 0) begin
            eq.push_back('{idx: i, is_ov: 1'b0, cyc: ecyc});
        end else if (m_held[i] && !rdy_stop) begin
            eq.push_back('{idx: i, is_ov: 1'b1, cyc: ecyc});
        end else begin
            dq.push_back('{idx: i, w: expect_word(i, seq), cyc: ecyc});
            m_held[i] = !rdy_stop;
        end
        si_v[i] = 1'b0;
        be_v[i] = 1'b1;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic release_word(input int i);
        rdy_v[i] = 1'b1;
        tick();
        tick();
        m_held[i] = 1'b0;
    endtask

    task automatic req_idle(input int i);
        idle_req[i] = 1'b1;
        @(negedge clk);
        #1;
        idle_req[i] = 1'b0;
        tick();
    endtask

    task automatic random_frames(input int i, input int n);
        logic [63:0] seq;
        logic        stopb, rd, rs;
        int          pace, gap;
        for (int f = 0; f < n; f++) begin
            seq   = {$urandom, $urandom};
            stopb = ($urandom_range(0, 4) == 0);
            pace  = $urandom_range(1, 3);
            rd    = $urandom_range(0, 1) != 0;
            rs    = $urandom_range(0, 1) != 0;
            gap   = rs ? $urandom_range(1, 3) : $urandom_range(0, 2);
            send_frame(i, seq, stopb, pace, rd, rs, gap);
        end
        release_word(i);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned dummy;
        rst   = 1'b1;
        si_v  = '0;
        be_v  = '1;
        rdy_v = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) tick();
        req_idle(0);
        req_idle(1);

        // default frame on the 40-bit receiver
        send_frame(0, 64'h00_A9F0AAAAA9, 1'b0, 1, 1'b1, 1'b1, 2);
        // LSB-first: bits 1,0,0,0,0,0,0,0 -> 8'h01
        send_frame(1, 64'h80, 1'b0, 1, 1'b1, 1'b1, 2);
        // bad stop bit: error on checked receiver, normal load on unchecked one
        send_frame(0, 64'h00_123456789A, 1'b1, 1, 1'b1, 1'b1, 2);
        send_frame(1, 64'h5C, 1'b1, 1, 1'b1, 1'b1, 2);

        // overrun with consumer stalled, back-to-back frames
        send_frame(0, 64'h00_1111111111, 1'b0, 1, 1'b0, 1'b0, 0);
        send_frame(0, 64'h00_2222222222, 1'b0, 1, 1'b0, 1'b0, 2);
        release_word(0);
        // consumer frees the register in the stop cycle: second word loads
        send_frame(0, 64'h00_1111111111, 1'b0, 1, 1'b0, 1'b0, 0);
        send_frame(0, 64'h00_2222222222, 1'b0, 1, 1'b0, 1'b1, 2);

        // sparse strobe, reset after 10 data bits, then a full sparse frame
        rdy_v[0] = 1'b1;
        step(0, 1'b1, 4, dummy);
        for (int k = 0; k < 10; k++) step(0, 1'($urandom_range(0, 1)), 4, dummy);
        si_v[0] = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        m_held = '0;
        req_idle(0);
        send_frame(0, 64'h00_C3A55A3CF1, 1'b0, 4, 1'b1, 1'b1, 2);
        send_frame(0, 64'h00_0F0F0F0F0F, 1'b1, 4, 1'b1, 1'b1, 2);

        random_frames(0, 25);
        random_frames(1, 30);

        repeat (4) tick();
        end_req = 1'b1;
        @(negedge clk);
        #1;
        end_req = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
